// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared state encoding and default framing constants for the TX framer
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAD,
        GAP
    } tx_state_t;

    localparam int TX_MIN_LEN_DEF = 64;
    localparam int TX_IFG_DEF     = 12;

endpackage

// File: rtl/tx_frame_ctrl_if.sv
// rtl/tx_frame_ctrl_if.sv - descriptor, byte-buffer and MAC stream signals of the TX framer
interface tx_frame_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 16
);
    logic [LEN_W-1:0]  frm_len;
    logic              frm_len_valid;
    logic              frm_len_ready;
    logic              buf_empty;
    logic              buf_rd;
    logic [DATA_W-1:0] buf_data;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_last;

    // master is the framer itself; slave is the buffer/MAC/descriptor side
    modport master (
        input  frm_len, frm_len_valid, buf_empty, buf_data, tx_ready,
        output frm_len_ready, buf_rd, tx_data, tx_valid, tx_last
    );

    modport slave (
        output frm_len, frm_len_valid, buf_empty, buf_data, tx_ready,
        input  frm_len_ready, buf_rd, tx_data, tx_valid, tx_last
    );
endinterface

// File: rtl/tx_skid_buf.sv
// rtl/tx_skid_buf.sv - 2-entry FIFO between buffer read returns and the MAC stream head
module tx_skid_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occupancy
);

    logic [DATA_W-1:0] mem0;
    logic [DATA_W-1:0] mem1;
    logic [1:0]        occ;
    logic              do_pop;
    logic              do_push;

    assign do_pop    = pop && (occ != 2'd0);
    assign do_push   = push && ((occ != 2'd2) || do_pop);
    assign head      = mem0;
    assign occupancy = occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0 <= '0;
            mem1 <= '0;
            occ  <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) mem0 <= push_data;
                    else             mem1 <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    mem0 <= mem1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // occupancy unchanged; the pushed word lands behind whatever survives the pop
                    if (occ == 2'd1) begin
                        mem0 <= push_data;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/tx_frame_ctrl.sv
// rtl/tx_frame_ctrl.sv - descriptor-driven TX framer with padding, inter-frame gap and underrun flag
module tx_frame_ctrl
    import tx_pkg::*;
#(
    parameter int                DATA_W     = 8,
    parameter int                LEN_W      = 16,
    parameter int                MIN_LEN    = TX_MIN_LEN_DEF,
    parameter logic [DATA_W-1:0] PAD_WORD   = '0,
    parameter int                IFG_CYCLES = TX_IFG_DEF
) (
    input  logic            clk,
    input  logic            rst,
    tx_frame_ctrl_if.master bus,
    output logic            len_err,
    output logic            underrun,
    output logic [15:0]     frame_cnt
);

    localparam logic [LEN_W-1:0] MIN_LEN_L  = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] ONE        = LEN_W'(1);
    localparam logic [7:0]       IFG_LAST   = (IFG_CYCLES == 0) ? 8'd0 : 8'(IFG_CYCLES - 1);
    localparam tx_state_t        POST_FRAME = (IFG_CYCLES == 0) ? IDLE : GAP;

    tx_state_t         state_q, state_d;
    logic [LEN_W-1:0]  len_q, total_q, rd_left_q, out_cnt_q;
    logic [7:0]        gap_cnt_q;
    logic              rd_inflight_q;
    logic              out_en_q;
    logic              len_err_q;
    logic              ur_seen_q;

    logic              sk_pop;
    logic [DATA_W-1:0] sk_head;
    logic [1:0]        sk_occ;
    logic [2:0]        pending;
    logic              desc_hs;
    logic              tx_hs;
    logic              last_word;
    logic              data_last;

    tx_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_inflight_q),
        .push_data (bus.buf_data),
        .pop       (sk_pop),
        .head      (sk_head),
        .occupancy (sk_occ)
    );

    assign desc_hs   = bus.frm_len_valid && bus.frm_len_ready;
    assign tx_hs     = bus.tx_valid && bus.tx_ready;
    assign last_word = (out_cnt_q == total_q - ONE);
    assign data_last = (out_cnt_q == len_q - ONE);
    // words held or already requested, after this cycle's pop leaves
    assign pending   = {1'b0, sk_occ} + {2'b00, rd_inflight_q} - {2'b00, sk_pop};
    assign len_err   = len_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d           = state_q;
        bus.frm_len_ready = 1'b0;
        bus.buf_rd        = 1'b0;
        bus.tx_valid      = 1'b0;
        bus.tx_data       = '0;
        sk_pop            = 1'b0;
        underrun          = 1'b0;
        case (state_q)
            IDLE: begin
                bus.frm_len_ready = out_en_q;
                if (desc_hs && (bus.frm_len != '0)) state_d = DATA;
            end
            DATA: begin
                bus.tx_valid = (sk_occ != 2'd0);
                bus.tx_data  = sk_head;
                sk_pop       = tx_hs;
                bus.buf_rd   = !bus.buf_empty && (rd_left_q != '0) && (pending < 3'd2);
                underrun     = (rd_left_q != '0) && (sk_occ == 2'd0) && !rd_inflight_q &&
                               bus.buf_empty && !ur_seen_q;
                if (tx_hs && data_last) state_d = (len_q < MIN_LEN_L) ? PAD : POST_FRAME;
            end
            PAD: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = PAD_WORD;
                if (tx_hs && last_word) state_d = POST_FRAME;
            end
            GAP: begin
                if (gap_cnt_q == IFG_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        bus.tx_last = bus.tx_valid && last_word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q         <= '0;
            total_q       <= '0;
            rd_left_q     <= '0;
            out_cnt_q     <= '0;
            gap_cnt_q     <= 8'd0;
            rd_inflight_q <= 1'b0;
            out_en_q      <= 1'b0;
            len_err_q     <= 1'b0;
            ur_seen_q     <= 1'b0;
            frame_cnt     <= 16'd0;
        end else begin
            out_en_q      <= 1'b1;
            len_err_q     <= 1'b0;
            rd_inflight_q <= bus.buf_rd;
            gap_cnt_q     <= (state_q == GAP) ? gap_cnt_q + 8'd1 : 8'd0;
            if (desc_hs) begin
                len_q     <= bus.frm_len;
                total_q   <= (bus.frm_len < MIN_LEN_L) ? MIN_LEN_L : bus.frm_len;
                rd_left_q <= bus.frm_len;
                out_cnt_q <= '0;
                ur_seen_q <= 1'b0;
                len_err_q <= (bus.frm_len == '0);
            end
            if (bus.buf_rd)             rd_left_q <= rd_left_q - ONE;
            if (tx_hs)                  out_cnt_q <= out_cnt_q + ONE;
            if (tx_hs && bus.tx_last)   frame_cnt <= frame_cnt + 16'd1;
            if (underrun)               ur_seen_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// tb/tb_tx_frame_ctrl.sv - directed self-checking bench for tx_frame_ctrl
module tb_tx_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        len_err;
    logic        underrun;
    logic [15:0] frame_cnt;
    logic        force_empty = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    tx_frame_ctrl_if #(.DATA_W(8), .LEN_W(16)) bus ();

    tx_frame_ctrl #(.DATA_W(8), .LEN_W(16), .MIN_LEN(64), .PAD_WORD(8'h00), .IFG_CYCLES(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .len_err   (len_err),
        .underrun  (underrun),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // byte buffer model: registered read data, flushed together with the framer
    logic [7:0] mem [0:1023];
    int         wr_cnt = 0;
    int         rd_ptr = 0;

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= wr_cnt;
            bus.buf_data <= 8'h00;
        end else if (bus.buf_rd) begin
            bus.buf_data <= mem[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    assign bus.buf_empty = force_empty || (rd_ptr >= wr_cnt);

    logic [7:0] words[$];
    int nlast, last_pos, rd_pulses, ur_pulses, le_pulses, stab_viol, drop_viol;
    int lat, span, gap, mid_idle, valid_cycles, timeout, forced;
    int bad, bad_idx;
    logic [7:0] bad_got, bad_exp;

    task automatic preload(input int n, input int base);
        for (int i = 0; i < n; i++) mem[wr_cnt + i] = 8'(base + i);
        wr_cnt = wr_cnt + n;
    endtask

    function automatic logic [7:0] exp_word(input int i, input int len, input int base);
        return (i < len) ? 8'(base + i) : 8'h00;
    endfunction

    task automatic scan_data(input int len, input int base);
        bad = 0; bad_idx = -1; bad_got = 8'h00; bad_exp = 8'h00;
        for (int i = 0; i < words.size(); i++) begin
            if (words[i] !== exp_word(i, len, base)) begin
                if (bad == 0) begin bad_idx = i; bad_got = words[i]; bad_exp = exp_word(i, len, base); end
                bad++;
            end
        end
    endtask

    task automatic run_frame(input int len, input bit toggle, input int empty_at, input int abort_at);
        int acc, first, lastc, cyc;
        bit accepted, done, prev_v, prev_r, prev_l;
        logic [7:0] prev_d;
        words.delete();
        nlast = 0; last_pos = -1; rd_pulses = 0; ur_pulses = 0; le_pulses = 0; stab_viol = 0;
        drop_viol = 0; gap = -1; mid_idle = 0; valid_cycles = 0; timeout = 0; forced = 0;
        acc = -1; first = -1; lastc = -1; accepted = 0; done = 0;
        prev_v = 0; prev_r = 0; prev_l = 0; prev_d = 8'h00;
        for (cyc = 0; cyc < 3000 && !done; cyc++) begin
            @(negedge clk);
            bus.frm_len       = 16'(len);
            bus.frm_len_valid = !accepted;
            bus.tx_ready      = toggle ? (cyc % 2 == 0) : 1'b1;
            force_empty       = (empty_at >= 0) && (words.size() >= empty_at) && (forced < 5);
            if (force_empty) forced++;
            #1;
            if (!accepted && bus.frm_len_valid && bus.frm_len_ready) begin accepted = 1; acc = cyc; end
            if (bus.buf_rd) rd_pulses++;
            if (underrun)   ur_pulses++;
            if (len_err)    le_pulses++;
            if (bus.tx_valid) begin
                if (first < 0) first = cyc;
                valid_cycles++;
                if (prev_v && !prev_r && (bus.tx_data !== prev_d || bus.tx_last !== prev_l)) stab_viol++;
            end else begin
                if (first >= 0 && lastc < 0) mid_idle++;
                if (prev_v && !prev_r) drop_viol++;
            end
            if (bus.tx_valid && bus.tx_ready) begin
                words.push_back(bus.tx_data);
                if (bus.tx_last) begin nlast++; last_pos = words.size() - 1; lastc = cyc; end
            end
            prev_v = bus.tx_valid; prev_r = bus.tx_ready; prev_l = bus.tx_last; prev_d = bus.tx_data;
            if (abort_at >= 0 && words.size() == abort_at) done = 1;
            if (lastc >= 0 && cyc > lastc && bus.frm_len_ready) begin gap = cyc - lastc - 1; done = 1; end
            if (len == 0 && accepted && cyc >= acc + 6) done = 1;
        end
        if (!done) timeout = 1;
        bus.frm_len_valid = 1'b0;
        bus.tx_ready      = 1'b0;
        force_empty       = 1'b0;
        lat  = (first >= 0) ? first - acc - 1 : -1;
        span = (lastc >= 0 && first >= 0) ? lastc - first : -1;
    endtask

    task automatic test_reset;
        bus.frm_len = 16'd0; bus.frm_len_valid = 1'b0; bus.tx_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (bus.frm_len_ready !== 1'b0) $display("FAIL reset_ready got %0b exp 0", bus.frm_len_ready); else n_pass++;
        n_chk++; if (bus.buf_rd !== 1'b0) $display("FAIL reset_buf_rd got %0b exp 0", bus.buf_rd); else n_pass++;
        n_chk++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid got %0b exp 0", bus.tx_valid); else n_pass++;
        n_chk++; if (bus.tx_last !== 1'b0) $display("FAIL reset_tx_last got %0b exp 0", bus.tx_last); else n_pass++;
        n_chk++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data got %0h exp 0", bus.tx_data); else n_pass++;
        n_chk++; if ({len_err, underrun} !== 2'b00) $display("FAIL reset_pulses got %b exp 00", {len_err, underrun}); else n_pass++;
        n_chk++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_full_frame;
        preload(100, 0);
        run_frame(100, 1'b0, -1, -1);
        scan_data(100, 0);
        n_chk++; if (timeout !== 0) $display("FAIL full_timeout got %0d exp 0", timeout); else n_pass++;
        n_chk++; if (words.size() !== 100) $display("FAIL full_count got %0d exp 100", words.size()); else n_pass++;
        n_chk++; if (bad !== 0) $display("FAIL full_data idx %0d got %0h exp %0h", bad_idx, bad_got, bad_exp); else n_pass++;
        n_chk++; if (last_pos !== 99 || nlast !== 1) $display("FAIL full_last got pos %0d n %0d exp pos 99 n 1", last_pos, nlast); else n_pass++;
        n_chk++; if (lat !== 2) $display("FAIL full_latency got %0d exp 2", lat); else n_pass++;
        n_chk++; if (span !== 99) $display("FAIL full_throughput got span %0d exp 99", span); else n_pass++;
        n_chk++; if (gap !== 12) $display("FAIL full_gap got %0d exp 12", gap); else n_pass++;
        n_chk++; if (rd_pulses !== 100) $display("FAIL full_reads got %0d exp 100", rd_pulses); else n_pass++;
        n_chk++; if (ur_pulses !== 0) $display("FAIL full_underrun got %0d exp 0", ur_pulses); else n_pass++;
        n_chk++; if (frame_cnt !== 16'd1) $display("FAIL full_frame_cnt got %0d exp 1", frame_cnt); else n_pass++;
    endtask

    task automatic test_short_pad;
        preload(10, 8'hA0);
        run_frame(10, 1'b0, -1, -1);
        scan_data(10, 8'hA0);
        n_chk++; if (words.size() !== 64) $display("FAIL pad_count got %0d exp 64", words.size()); else n_pass++;
        n_chk++; if (bad !== 0) $display("FAIL pad_data idx %0d got %0h exp %0h", bad_idx, bad_got, bad_exp); else n_pass++;
        n_chk++; if (last_pos !== 63 || nlast !== 1) $display("FAIL pad_last got pos %0d n %0d exp pos 63 n 1", last_pos, nlast); else n_pass++;
        n_chk++; if (rd_pulses !== 10) $display("FAIL pad_reads got %0d exp 10", rd_pulses); else n_pass++;
        n_chk++; if (frame_cnt !== 16'd2) $display("FAIL pad_frame_cnt got %0d exp 2", frame_cnt); else n_pass++;
    endtask

    task automatic test_zero_len;
        run_frame(0, 1'b0, -1, -1);
        n_chk++; if (timeout !== 0) $display("FAIL zero_timeout got %0d exp 0", timeout); else n_pass++;
        n_chk++; if (le_pulses !== 1) $display("FAIL zero_len_err got %0d exp 1", le_pulses); else n_pass++;
        n_chk++; if (rd_pulses !== 0) $display("FAIL zero_reads got %0d exp 0", rd_pulses); else n_pass++;
        n_chk++; if (valid_cycles !== 0) $display("FAIL zero_valid got %0d exp 0", valid_cycles); else n_pass++;
        n_chk++; if (frame_cnt !== 16'd2) $display("FAIL zero_frame_cnt got %0d exp 2", frame_cnt); else n_pass++;
    endtask

    task automatic test_backpressure;
        preload(70, 8'h10);
        run_frame(70, 1'b1, -1, -1);
        scan_data(70, 8'h10);
        n_chk++; if (words.size() !== 70) $display("FAIL bp_count got %0d exp 70", words.size()); else n_pass++;
        n_chk++; if (bad !== 0) $display("FAIL bp_data idx %0d got %0h exp %0h", bad_idx, bad_got, bad_exp); else n_pass++;
        n_chk++; if (stab_viol !== 0) $display("FAIL bp_stable got %0d exp 0", stab_viol); else n_pass++;
        n_chk++; if (drop_viol !== 0) $display("FAIL bp_valid_drop got %0d exp 0", drop_viol); else n_pass++;
        n_chk++; if (nlast !== 1 || last_pos !== 69) $display("FAIL bp_last got n %0d pos %0d exp n 1 pos 69", nlast, last_pos); else n_pass++;
        n_chk++; if (frame_cnt !== 16'd3) $display("FAIL bp_frame_cnt got %0d exp 3", frame_cnt); else n_pass++;
    endtask

    task automatic test_underrun;
        preload(80, 8'h40);
        run_frame(80, 1'b0, 20, -1);
        scan_data(80, 8'h40);
        n_chk++; if (ur_pulses !== 1) $display("FAIL ur_pulses got %0d exp 1", ur_pulses); else n_pass++;
        n_chk++; if ((mid_idle > 0) !== 1'b1) $display("FAIL ur_valid_low got %0d idle cycles exp >0", mid_idle); else n_pass++;
        n_chk++; if (words.size() !== 80) $display("FAIL ur_count got %0d exp 80", words.size()); else n_pass++;
        n_chk++; if (bad !== 0) $display("FAIL ur_data idx %0d got %0h exp %0h", bad_idx, bad_got, bad_exp); else n_pass++;
        n_chk++; if (last_pos !== 79 || nlast !== 1) $display("FAIL ur_last got pos %0d n %0d exp pos 79 n 1", last_pos, nlast); else n_pass++;
        n_chk++; if (frame_cnt !== 16'd4) $display("FAIL ur_frame_cnt got %0d exp 4", frame_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        preload(100, 8'h80);
        run_frame(100, 1'b0, -1, 30);
        rst = 1'b1;
        #1;
        n_chk++; if ({bus.tx_valid, bus.tx_last, bus.buf_rd, bus.frm_len_ready} !== 4'b0000)
            $display("FAIL midrst_ctrl got %b exp 0000", {bus.tx_valid, bus.tx_last, bus.buf_rd, bus.frm_len_ready}); else n_pass++;
        n_chk++; if (bus.tx_data !== 8'h00) $display("FAIL midrst_tx_data got %0h exp 0", bus.tx_data); else n_pass++;
        n_chk++; if (frame_cnt !== 16'd0) $display("FAIL midrst_frame_cnt got %0d exp 0", frame_cnt); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        preload(64, 8'h20);
        run_frame(64, 1'b0, -1, -1);
        scan_data(64, 8'h20);
        n_chk++; if (words.size() !== 64) $display("FAIL midrst_count got %0d exp 64", words.size()); else n_pass++;
        n_chk++; if (bad !== 0) $display("FAIL midrst_data idx %0d got %0h exp %0h", bad_idx, bad_got, bad_exp); else n_pass++;
        n_chk++; if (last_pos !== 63 || nlast !== 1) $display("FAIL midrst_last got pos %0d n %0d exp pos 63 n 1", last_pos, nlast); else n_pass++;
        n_chk++; if (frame_cnt !== 16'd1) $display("FAIL midrst_frame_cnt got %0d exp 1", frame_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_short_pad();
        test_zero_len();
        test_backpressure();
        test_underrun();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/tx_frame_ctrl.md
Name: tx_frame_ctrl

Overview:
- Parametrised TX framer between the frame byte buffer and the MAC transmit interface.
- Accepts a length descriptor, then pulls that many bytes from the buffer.
- Drives them out on a valid/ready/last stream, padding short frames to a minimum length and enforcing an inter-frame gap.
- Replaces the fixed-width, pointer-driven TX control with a descriptor/skid-buffer architecture that sustains one byte per cycle.

Parameters:
- DATA_W, 8: stream and buffer data width in bits.
- LEN_W, 16: width of the frame-length descriptor and byte counter.
- MIN_LEN, 64: minimum emitted frame length in words; shorter frames are padded.
- PAD_WORD, 0: value of padding words.
- IFG_CYCLES, 12: idle cycles forced after each tx_last handshake; legal range 0..255.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous reset, active-high.
- frm_len  in  LEN_W  frame length in words.
- frm_len_valid  in  1  descriptor present.
- frm_len_ready  out  1  descriptor accepted when valid&&ready.
- buf_empty  in  1  byte buffer empty.
- buf_rd  out  1  buffer read strobe; data returns on buf_data next cycle.
- buf_data  in  DATA_W  buffer read data, valid one cycle after buf_rd.
- tx_data  out  DATA_W  word to MAC.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  MAC accepts when valid&&ready.
- tx_last  out  1  marks final word of frame, qualified by tx_valid.
- len_err  out  1  one-cycle pulse: zero-length descriptor consumed.
- underrun  out  1  one-cycle pulse, at most once per frame: buffer empty while data words still owed.
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0.

Behaviour:
- Reset (async, rst=1): state IDLE, all counters 0, skid buffer flushed, in-flight read discarded.
- Reset values: frm_len_ready=0, buf_rd=0, tx_valid=0, tx_last=0, tx_data=0, len_err=0, underrun=0, frame_cnt=0.
- Reset mid-frame: frame abandoned with no tx_last; the buffer is not resynchronised. Upstream is reset together with this block.
- States:
  - IDLE: frm_len_ready=1. On handshake, latch len=frm_len. If len==0, pulse len_err next cycle and stay IDLE. Otherwise go to DATA, with data_left=len and total=max(len,MIN_LEN).
  - DATA:
    - Issue buf_rd when !buf_empty && data_left_to_read>0 && (skid_occupancy + read_in_flight - pop_this_cycle) < 2.
    - Returned words are pushed into the 2-entry skid buffer; the skid head drives tx_data/tx_valid.
    - Each output handshake decrements the remaining-output counter.
    - When all len data words are handshaken: go to PAD if len<MIN_LEN, else GAP.
  - PAD: tx_valid=1, tx_data=PAD_WORD until total words are sent, then go to GAP.
  - GAP: tx_valid=0 for IFG_CYCLES cycles, then IDLE. With IFG_CYCLES=0, go directly to IDLE.
- tx_last=1 exactly on the word whose index is total-1, whether that is a data or a pad word.
- Stream rules:
  - While tx_valid=1 and tx_ready=0, tx_data and tx_last hold stable.
  - tx_valid never drops without a handshake, except on reset.
  - tx_valid may be low mid-DATA only when the skid buffer is empty (underrun).
- Throughput: with buffer non-empty and tx_ready=1, one word per cycle after a 2-cycle fill latency.
  - Latency: descriptor handshake to first tx_valid = 2 cycles (read issue, data return into skid head).
- Underrun: data words still owed, skid empty, and buf_empty=1 -> pulse underrun once on the first such cycle of the frame. Wait without error until data arrives.
- frame_cnt increments on the tx_last handshake.
- Width rules:
  - total and counters are LEN_W.
  - MIN_LEN must be < 2^LEN_W.
  - frm_len=2^LEN_W-1 is legal.
- Simultaneous events: a skid pop and push in the same cycle keep occupancy constant. A descriptor is never accepted outside IDLE.

Decomposition:
- Shared package tx_pkg holds the state enumeration (IDLE, DATA, PAD, GAP) and the default MIN_LEN/IFG constants.
- One sub-module: tx_skid_buf, a 2-entry DATA_W-bit FIFO with push/pop/occupancy (clk, rst async active-high).

Test Plan:
- len=100, buffer preloaded with 100 bytes 0x00..0x63, tx_ready=1 -> 100 consecutive words, tx_last on 0x63, then 12 idle cycles, frame_cnt=1.
- len=10 -> 10 data words, then 54 words 0x00; tx_last on word 63; exactly 10 buf_rd pulses.
- len=0 -> frm_len_ready handshake, len_err pulse, no buf_rd, no tx_valid, frame_cnt unchanged.
- len=70, tx_ready toggling 1/0 every cycle -> data stable while stalled, 70 words in order, no skid overflow, single tx_last.
- len=80, buf_empty forced high after 20 words for 5 cycles -> one underrun pulse, tx_valid low while skid empty, resume, 80 words total, tx_last on word 79.
- rst asserted at word 30 of a 100-word frame -> all outputs 0 immediately; after release, a new len=64 frame completes normally, frame_cnt=1.
